// File: rtl/vram_arbiter_m.sv
// Single-port VRAM arbiter: GPU pixel fetch vs. 6502 bus, with a one-entry
// posted write buffer, a stalling read path and a starvation escape for the CPU.
module vram_arbiter_m #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vblank_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rdy_o,
  input  logic              gpu_req_i,
  input  logic [ADDR_W-1:0] gpu_addr_i,
  output logic              gpu_gnt_o,
  output logic              gpu_rvalid_o,
  output logic [DATA_W-1:0] gpu_rdata_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic              vram_we_o,
  output logic [DATA_W-1:0] vram_wdata_o,
  input  logic [DATA_W-1:0] vram_rdata_i
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DONE} state_e;

  state_e              state_q, state_d;
  logic                wbuf_full_q, wbuf_full_d;
  logic [ADDR_W-1:0]   wbuf_addr_q, wbuf_addr_d;
  logic [DATA_W-1:0]   wbuf_data_q, wbuf_data_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [ADDR_W-1:0]   vram_addr_q;
  logic [DATA_W-1:0]   vram_wdata_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic                gpu_rvalid_q;
  logic [DATA_W-1:0]   gpu_rdata_q;

  logic eff_rd, cpu_cand, cpu_gnt, drain, rd_gnt, wr_acc;

  // A read seen in IDLE is treated as RD_ISSUE in the same cycle for minimum latency.
  assign eff_rd   = (state_q == RD_ISSUE) |
                    ((state_q == IDLE) & cpu_req_i & ~cpu_we_i);
  assign cpu_cand = wbuf_full_q | eff_rd;
  assign drain    = cpu_gnt & wbuf_full_q;
  assign rd_gnt   = cpu_gnt & ~wbuf_full_q;
  assign wr_acc   = (state_q == IDLE) & cpu_req_i & cpu_we_i & (~wbuf_full_q | drain);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RD_ISSUE: begin
        if (rd_gnt)      state_d = RD_DONE;
        else if (eff_rd) state_d = RD_ISSUE;
        else             state_d = IDLE;
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: slot ownership, VRAM bus and CPU handshake
  always_comb begin
    cpu_gnt   = 1'b0;
    gpu_gnt_o = 1'b0;
    if (!rst) begin
      if (in_vblank_i) begin
        if (cpu_cand) cpu_gnt = 1'b1;
        else          gpu_gnt_o = gpu_req_i;
      end else if (cpu_cand && (starve_q == STARVE_TOP || !gpu_req_i)) begin
        cpu_gnt = 1'b1;
      end else begin
        gpu_gnt_o = gpu_req_i;
      end
    end

    vram_we_o    = drain;
    vram_wdata_o = drain ? wbuf_data_q : vram_wdata_q;
    if (rd_gnt)         vram_addr_o = cpu_addr_i;
    else if (drain)     vram_addr_o = wbuf_addr_q;
    else if (gpu_gnt_o) vram_addr_o = gpu_addr_i;
    else                vram_addr_o = vram_addr_q;

    case (state_q)
      IDLE:     cpu_rdy_o = ~cpu_req_i | wr_acc;
      RD_ISSUE: cpu_rdy_o = 1'b0;
      default:  cpu_rdy_o = 1'b1;
    endcase
  end

  // Read data appears on the VRAM port during RD_DONE / the cycle after a GPU grant
  // and is then held in the _q copies until the next return.
  assign cpu_rdata_o  = (state_q == RD_DONE) ? vram_rdata_i : cpu_rdata_q;
  assign gpu_rvalid_o = gpu_rvalid_q;
  assign gpu_rdata_o  = gpu_rvalid_q ? vram_rdata_i : gpu_rdata_q;

  always_comb begin
    wbuf_full_d = wbuf_full_q;
    wbuf_addr_d = wbuf_addr_q;
    wbuf_data_d = wbuf_data_q;
    if (wr_acc) begin
      wbuf_full_d = 1'b1;
      wbuf_addr_d = cpu_addr_i;
      wbuf_data_d = cpu_wdata_i;
    end else if (drain) begin
      wbuf_full_d = 1'b0;
    end

    if (cpu_cand && !cpu_gnt)
      starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + SW'(1);
    else
      starve_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbuf_full_q  <= 1'b0;
      wbuf_addr_q  <= '0;
      wbuf_data_q  <= '0;
      starve_q     <= '0;
      vram_addr_q  <= '0;
      vram_wdata_q <= '0;
      cpu_rdata_q  <= '0;
      gpu_rvalid_q <= 1'b0;
      gpu_rdata_q  <= '0;
    end else begin
      wbuf_full_q  <= wbuf_full_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_data_q  <= wbuf_data_d;
      starve_q     <= starve_d;
      vram_addr_q  <= vram_addr_o;
      vram_wdata_q <= vram_wdata_o;
      gpu_rvalid_q <= gpu_gnt_o;
      if (state_q == RD_DONE) cpu_rdata_q <= vram_rdata_i;
      if (gpu_rvalid_q)       gpu_rdata_q <= vram_rdata_i;
    end
  end

endmodule

// File: tb/tb_vram_arbiter_m.sv
// Bench for vram_arbiter_m: directed scenarios followed by randomized CPU/GPU
// traffic checked against a plain memory model and protocol rules.
module tb_vram_arbiter_m;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vblank;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_rdy;
  logic        gpu_req;
  logic [11:0] gpu_addr;
  logic        gpu_gnt, gpu_rvalid;
  logic [7:0]  gpu_rdata;
  logic [11:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata, vram_rdata;

  logic [7:0]  mem [0:4095];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [0:15];
  logic       prev_gnt = 1'b0;
  logic [7:0] prev_exp = '0;
  logic       mon_armed = 1'b0;

  vram_arbiter_m dut (
    .clk(clk), .rst(rst), .in_vblank_i(in_vblank),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_rdy_o(cpu_rdy),
    .gpu_req_i(gpu_req), .gpu_addr_i(gpu_addr), .gpu_gnt_o(gpu_gnt),
    .gpu_rvalid_o(gpu_rvalid), .gpu_rdata_o(gpu_rdata),
    .vram_addr_o(vram_addr), .vram_we_o(vram_we), .vram_wdata_o(vram_wdata),
    .vram_rdata_i(vram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port VRAM with a backdoor preload port.
  always @(posedge clk) begin
    if (vram_we)    mem[vram_addr] <= vram_wdata;
    else if (bd_we) mem[bd_addr] <= bd_data;
    vram_rdata <= mem[vram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    nxt();
    bd_we = 1'b0;
  endtask

  task automatic rnd_bg();
    in_vblank = ($urandom_range(0, 3) == 0);
    gpu_req   = $urandom_range(0, 1) == 1;
    gpu_addr  = 12'h040 + 12'($urandom_range(0, 15));
  endtask

  // Per-cycle protocol checks for the random phase, then advance one clock.
  task automatic mon_tick();
    if (mon_armed) begin
      chk("rand_gpu_rvalid", gpu_rvalid, prev_gnt);
      if (prev_gnt) chk("rand_gpu_rdata", gpu_rdata, prev_exp);
    end
    chk("rand_gnt_needs_req", gpu_gnt & ~gpu_req, 0);
    chk("rand_we_excl", vram_we & gpu_gnt, 0);
    prev_gnt  = gpu_gnt;
    prev_exp  = mem[gpu_addr];
    mon_armed = 1'b1;
    nxt();
  endtask

  task automatic rand_xact(input logic we, input logic [3:0] idx, input logic [7:0] d);
    int waited;
    rnd_bg();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = 12'h040 + 12'(idx); cpu_wdata = d;
    settle();
    waited = 0;
    while (!cpu_rdy && waited < 40) begin
      mon_tick(); rnd_bg(); settle();
      waited++;
    end
    chk("rand_rdy_bound", waited < 40, 1);
    if (!we) chk("rand_rd_data", cpu_rdata, ref_mem[idx]);
    else     ref_mem[idx] = d;
    $display("xact %s addr=%03h data=%02h stall=%0d", we ? "WR" : "RD", cpu_addr,
             we ? d : cpu_rdata, waited);
    mon_tick();
    cpu_req = 1'b0;
    rnd_bg(); settle();
    for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
      mon_tick(); rnd_bg(); settle();
    end
  endtask

  initial begin
    int stall;
    int we_pulses;
    rst = 1'b1; in_vblank = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; gpu_req = 1'b0; gpu_addr = '0;
    nxt();
    preload(12'h100, 8'h77);
    preload(12'h005, 8'h5A);
    preload(12'h030, 8'hEE);
    nxt();
    rst = 1'b0;
    settle();

    // Reset state
    chk("rst_cpu_rdy", cpu_rdy, 1);
    chk("rst_gpu_gnt", gpu_gnt, 0);
    chk("rst_gpu_rvalid", gpu_rvalid, 0);
    chk("rst_vram_we", vram_we, 0);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_vram_wdata", vram_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_gpu_rdata", gpu_rdata, 0);
    $display("reset checked");

    // 1: posted write in vblank
    nxt();
    in_vblank = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 8'hA5;
    settle();
    chk("t1_rdy_same_cycle", cpu_rdy, 1);
    chk("t1_no_we_yet", vram_we, 0);
    nxt(); cpu_req = 1'b0; settle();
    chk("t1_drain_we", vram_we, 1);
    chk("t1_drain_addr", vram_addr, 12'h010);
    chk("t1_drain_data", vram_wdata, 8'hA5);
    nxt(); settle();
    chk("t1_we_done", vram_we, 0);
    chk("t1_mem", mem[12'h010], 8'hA5);
    $display("test1 write 010=A5 done");

    // 2: write then read same address in vblank
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 8'h3C; settle();
    chk("t2_wr_rdy", cpu_rdy, 1);
    nxt(); cpu_we = 1'b0; settle();
    chk("t2_rd_stall", cpu_rdy, 0);
    chk("t2_drain_first", vram_we, 1);
    chk("t2_drain_addr", vram_addr, 12'h020);
    nxt(); settle();
    chk("t2_rd_issue_we", vram_we, 0);
    chk("t2_rd_issue_addr", vram_addr, 12'h020);
    chk("t2_rd_issue_rdy", cpu_rdy, 0);
    nxt(); settle();
    chk("t2_rd_rdy", cpu_rdy, 1);
    chk("t2_rd_data", cpu_rdata, 8'h3C);
    nxt(); cpu_req = 1'b0; settle();
    chk("t2_rdata_hold", cpu_rdata, 8'h3C);
    $display("test2 write/read 020 data=%02h", cpu_rdata);

    // 3: starvation escape for a read during active display
    nxt();
    in_vblank = 1'b0; gpu_req = 1'b1; gpu_addr = 12'h200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h005; settle();
    for (int i = 0; i < 8; i++) begin
      chk("t3_gpu_gnt", gpu_gnt, 1);
      chk("t3_rdy_low", cpu_rdy, 0);
      nxt(); settle();
    end
    chk("t3_gpu_denied", gpu_gnt, 0);
    chk("t3_cpu_slot_addr", vram_addr, 12'h005);
    chk("t3_rdy_low9", cpu_rdy, 0);
    nxt(); settle();
    chk("t3_rdy10", cpu_rdy, 1);
    chk("t3_rdata", cpu_rdata, 8'h5A);
    $display("test3 starved read 005 data=%02h", cpu_rdata);
    cpu_req = 1'b0; gpu_req = 1'b0;
    nxt(); nxt();

    // 4: GPU fetch latency
    gpu_req = 1'b1; gpu_addr = 12'h100; settle();
    chk("t4_gnt", gpu_gnt, 1);
    chk("t4_addr", vram_addr, 12'h100);
    nxt(); gpu_req = 1'b0; settle();
    chk("t4_rvalid", gpu_rvalid, 1);
    chk("t4_rdata", gpu_rdata, 8'h77);
    nxt(); settle();
    chk("t4_rvalid_drop", gpu_rvalid, 0);
    chk("t4_rdata_hold", gpu_rdata, 8'h77);
    $display("test4 gpu fetch 100 data=77");

    // 5: back-to-back writes against a busy GPU
    gpu_req = 1'b1; gpu_addr = 12'h200;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h001; cpu_wdata = 8'h11; settle();
    chk("t5_wr1_rdy", cpu_rdy, 1);
    nxt(); cpu_addr = 12'h002; cpu_wdata = 8'h22; settle();
    stall = 0;
    while (!cpu_rdy && stall < 30) begin
      chk("t5_gpu_owns", gpu_gnt, 1);
      nxt(); settle();
      stall++;
    end
    chk("t5_stall_len", stall, 8);
    chk("t5_drain_on_accept", vram_we, 1);
    nxt(); cpu_req = 1'b0; gpu_req = 1'b0;
    nxt(); nxt(); settle();
    chk("t5_mem1", mem[12'h001], 8'h11);
    chk("t5_mem2", mem[12'h002], 8'h22);
    $display("test5 writes 001=%02h 002=%02h stall=%0d", mem[12'h001], mem[12'h002], stall);

    // 6: reset while a read waits behind a buffered write
    gpu_req = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h030; cpu_wdata = 8'h99; settle();
    nxt(); cpu_we = 1'b0; cpu_addr = 12'h031; settle();
    nxt(); settle();
    chk("t6_rd_issue_stall", cpu_rdy, 0);
    nxt(); rst = 1'b1; settle();
    chk("t6_rst_no_we", vram_we, 0);
    chk("t6_rst_no_gnt", gpu_gnt, 0);
    nxt(); rst = 1'b0; cpu_req = 1'b0; gpu_req = 1'b0; settle();
    chk("t6_rdy_after_rst", cpu_rdy, 1);
    we_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      in_vblank = (i % 2 == 0);
      settle();
      if (vram_we) we_pulses++;
      nxt();
    end
    chk("t6_no_we_pulse", we_pulses, 0);
    chk("t6_mem_unchanged", mem[12'h030], 8'hEE);
    $display("test6 reset abort, mem[030]=%02h", mem[12'h030]);

    // Random phase: seed every address, then mixed traffic
    for (int i = 0; i < 16; i++) rand_xact(1'b1, 4'(i), 8'($urandom));
    for (int i = 0; i < 150; i++)
      rand_xact($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), 8'($urandom));
    cpu_req = 1'b0; gpu_req = 1'b0; in_vblank = 1'b0; settle();
    for (int i = 0; i < 4; i++) mon_tick();
    settle();
    for (int i = 0; i < 16; i++) chk("final_mem", mem[12'h040 + 12'(i)], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
